// File: rtl/out_port_tx.sv
// -----------------------------------------------------------------------------
// out_port_tx
//
// Serializer for the CPU's 16-bit output port. Each word strobed in with
// din_valid is queued in a small FIFO and then sent on a single UART line as
// two frames, low byte first. The CPU can write at instruction rate while the
// line drains at bit rate.
//
// Build option:
//   OUT_PORT_TX_PARITY_EN  defined   -> 8E1 frames (even-parity bit after data)
//                          undefined -> 8N1 frames
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit (>= 2)
//   FIFO_DEPTH    FIFO capacity in words (power of two, >= 2)
//
// Ports:
//   clk         sole clock, rising edge
//   rst_n       asynchronous active-low reset
//   din         word from the CPU output port
//   din_valid   enqueue strobe (CPU output_valid)
//   tx          serial line, registered, idles high
//   busy        FIFO non-empty or transmitter not idle
//   overflow    sticky: a word was dropped because the FIFO was full
//   fifo_count  words currently held in the FIFO
//   dbg_state   current transmitter FSM state
//
// Handshake: din_valid is a one-cycle strobe with no ready. A strobed word is
// taken at the rising edge when the FIFO has room, or when the transmitter
// pops at that same edge; otherwise it is dropped and overflow latches high.
// -----------------------------------------------------------------------------
module out_port_tx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [15:0]                   din,
   input  logic                          din_valid,
   output logic                          tx,
   output logic                          busy,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic [2:0]                    dbg_state
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

`ifdef OUT_PORT_TX_PARITY_EN
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_t;
`else
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_STOP   = 3'd4
   } state_t;
`endif

   // FIFO storage and bookkeeping
   logic [15:0]   r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          r_overflow;

   // Transmitter
   state_t        r_state;
   logic          r_tx;
   logic [BW-1:0] r_baud;
   logic [2:0]    r_bit_idx;
   logic          r_byte_sel;
   logic [15:0]   r_word;

   logic          w_full;
   logic          w_empty;
   logic          w_pop;
   logic          w_push;
   logic          w_baud_end;
   logic [7:0]    w_byte;
   logic [2:0]    w_next_idx;

   assign w_full     = (r_count == CW'(FIFO_DEPTH));
   assign w_empty    = (r_count == '0);
   // The FSM only sees the registered count, so a word pushed into an empty
   // FIFO is popped one cycle later (no bypass path).
   assign w_pop      = (r_state == ST_IDLE) && !w_empty;
   // A pop at the same edge frees a slot, so a full FIFO can still accept.
   assign w_push     = din_valid && (!w_full || w_pop);
   assign w_baud_end = (r_baud == BW'(CLKS_PER_BIT - 1));
   assign w_byte     = r_byte_sel ? r_word[15:8] : r_word[7:0];
   assign w_next_idx = r_bit_idx + 3'd1;

   // ---------------------------------------------------------------- FIFO
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
         if (din_valid && !w_push) begin
            r_overflow <= 1'b1;
         end
      end
   end

   // --------------------------------------------------------- Transmitter
   // r_tx is loaded with the level of the state being entered, so the line
   // changes on the same edge as the state and stays glitch-free.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_tx       <= 1'b1;
         r_baud     <= '0;
         r_bit_idx  <= '0;
         r_byte_sel <= 1'b0;
         r_word     <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_tx   <= 1'b1;
               r_baud <= '0;
               if (w_pop) begin
                  r_word     <= r_mem[r_rd_ptr];
                  r_byte_sel <= 1'b0;
                  r_tx       <= 1'b0;
                  r_state    <= ST_START;
               end
            end

            ST_START: begin
               if (w_baud_end) begin
                  r_baud    <= '0;
                  r_bit_idx <= '0;
                  r_tx      <= w_byte[0];
                  r_state   <= ST_DATA;
               end else begin
                  r_baud <= r_baud + BW'(1);
               end
            end

            ST_DATA: begin
               if (w_baud_end) begin
                  r_baud <= '0;
                  if (r_bit_idx == 3'd7) begin
`ifdef OUT_PORT_TX_PARITY_EN
                     // Even parity: line bit makes total ones even.
                     r_tx    <= ^w_byte;
                     r_state <= ST_PARITY;
`else
                     r_tx    <= 1'b1;
                     r_state <= ST_STOP;
`endif
                  end else begin
                     r_bit_idx <= w_next_idx;
                     r_tx      <= w_byte[w_next_idx];
                  end
               end else begin
                  r_baud <= r_baud + BW'(1);
               end
            end

`ifdef OUT_PORT_TX_PARITY_EN
            ST_PARITY: begin
               if (w_baud_end) begin
                  r_baud  <= '0;
                  r_tx    <= 1'b1;
                  r_state <= ST_STOP;
               end else begin
                  r_baud <= r_baud + BW'(1);
               end
            end
`endif

            ST_STOP: begin
               if (w_baud_end) begin
                  r_baud <= '0;
                  if (!r_byte_sel) begin
                     // High byte follows immediately, no idle gap.
                     r_byte_sel <= 1'b1;
                     r_tx       <= 1'b0;
                     r_state    <= ST_START;
                  end else begin
                     r_tx    <= 1'b1;
                     r_state <= ST_IDLE;
                  end
               end else begin
                  r_baud <= r_baud + BW'(1);
               end
            end

            default: begin
               r_tx    <= 1'b1;
               r_baud  <= '0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign tx         = r_tx;
   assign busy       = (r_state != ST_IDLE) || !w_empty;
   assign overflow   = r_overflow;
   assign fifo_count = r_count;
   assign dbg_state  = r_state;

endmodule

// File: tb/tb_out_port_tx.sv
// -----------------------------------------------------------------------------
// tb_out_port_tx
//
// Directed bench for out_port_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4. Words are
// pushed to an expected queue as they are driven (when they should be
// accepted); a serial receiver decodes the tx line and pops/compares each
// reassembled word. Timing points (first-edge latency, word length, gaps,
// FIFO counts) are checked directly from the main sequence.
// -----------------------------------------------------------------------------
module tb_out_port_tx;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
`ifdef OUT_PORT_TX_PARITY_EN
   localparam int WORD_CYC = 22 * CPB;
`else
   localparam int WORD_CYC = 20 * CPB;
`endif

   logic        clk;
   logic        rst_n;
   logic [15:0] din;
   logic        din_valid;
   logic        tx;
   logic        busy;
   logic        overflow;
   logic [2:0]  fifo_count;
   logic [2:0]  dbg_state;

   out_port_tx #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .din        (din),
      .din_valid  (din_valid),
      .tx         (tx),
      .busy       (busy),
      .overflow   (overflow),
      .fifo_count (fifo_count),
      .dbg_state  (dbg_state)
   );

   // ------------------------------------------------------ clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int rst_events = 0;
   always @(negedge rst_n) rst_events++;

   // --------------------------------------------------------- scoreboard
   logic [15:0] exp_q[$];
   int n_pass  = 0;
   int n_fail  = 0;
   int n_total = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // ------------------------------------------------------------ drivers
   task automatic drive_push(input logic [15:0] w, input bit accept);
      din       = w;
      din_valid = 1'b1;
      if (accept) exp_q.push_back(w);
      @(posedge clk);
      #1;
      din_valid = 1'b0;
      din       = 16'($urandom_range(0, 65535));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic wait_busy_low(input int limit, output int n);
      n = 0;
      while (busy !== 1'b0 && n < limit) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   // --------------------------------------------------- serial receiver
   bit          chk_gap   = 1'b0;
   bit          gap_valid = 1'b0;
   int          last_lo_cyc = 0;
   bit          rx_have_lo = 1'b0;
   logic [7:0]  rx_lo;

   initial begin : rx_monitor
      logic [7:0] b;
      logic       stp;
`ifdef OUT_PORT_TX_PARITY_EN
      logic       par;
`endif
      int         st_rst;
      int         st_cyc;
      forever begin
         @(negedge clk);
         if (!chk_gap) gap_valid = 1'b0;
         if (rst_n !== 1'b1) begin
            rx_have_lo = 1'b0;
         end else if (tx === 1'b0) begin
            st_rst = rst_events;
            st_cyc = cyc;
            repeat (2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) @(negedge clk);
               b[i] = tx;
            end
`ifdef OUT_PORT_TX_PARITY_EN
            repeat (CPB) @(negedge clk);
            par = tx;
`endif
            repeat (CPB) @(negedge clk);
            stp = tx;
            if (st_rst != rst_events) begin
               rx_have_lo = 1'b0;
            end else begin
               check("rx_stop_bit", 32'(stp), 32'd1);
`ifdef OUT_PORT_TX_PARITY_EN
               check("rx_parity", 32'(par), 32'(^b));
`endif
               if (!rx_have_lo) begin
                  if (chk_gap && gap_valid)
                     check("word_spacing", 32'(st_cyc - last_lo_cyc), 32'(WORD_CYC + 1));
                  last_lo_cyc = st_cyc;
                  gap_valid   = chk_gap;
                  rx_lo       = b;
                  rx_have_lo  = 1'b1;
               end else begin
                  rx_have_lo = 1'b0;
                  check("rx_word_expected", 32'(exp_q.size() != 0), 32'd1);
                  if (exp_q.size() != 0)
                     check("rx_word", 32'({b, rx_lo}), 32'(exp_q.pop_front()));
               end
            end
         end
      end
   end

   // ---------------------------------------------------------- stimulus
   int n;
   int zeros;
   int cyc0;
   logic [2:0] ovf_cnt [6] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
   logic [15:0] fp_words [6] = '{16'h1234, 16'hBEEF, 16'h0F0F, 16'h8001, 16'h7E81, 16'hC0DE};
   logic [2:0]  fp_cnt [5] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4};

   initial begin
      rst_n     = 1'b0;
      din       = 16'h0000;
      din_valid = 1'b0;

      // Reset
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_tx_held", 32'(tx), 32'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("reset_tx", 32'(tx), 32'd1);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_overflow", 32'(overflow), 32'd0);
      check("reset_count", 32'(fifo_count), 32'd0);
      check("reset_state", 32'(dbg_state), 32'd0);
      zeros = 0;
      repeat (50) begin
         @(negedge clk);
         if (tx !== 1'b1) zeros++;
      end
      check("idle_tx_50", 32'(zeros), 32'd0);

      // Single word
      drive_push(16'hA55A, 1'b1);
      @(negedge clk);
      check("single_count_k", 32'(fifo_count), 32'd1);
      check("single_tx_k", 32'(tx), 32'd1);
      check("single_busy_k", 32'(busy), 32'd1);
      @(negedge clk);
      cyc0 = cyc;
      check("single_count_k1", 32'(fifo_count), 32'd0);
      zeros = 1;
      if (tx !== 1'b0) zeros = 0;
      repeat (7) begin
         @(negedge clk);
         if (tx === 1'b0) zeros++;
      end
      check("single_start_bit0_low", 32'(zeros), 32'd8);
      @(negedge clk);
      check("single_bit1_high", 32'(tx), 32'd1);
      wait_busy_low(400, n);
      check("single_busy_timeout", 32'(n < 400), 32'd1);
      check("single_word_len", 32'(cyc - cyc0), 32'(WORD_CYC));
      check("single_rx_done", 32'(exp_q.size()), 32'd0);

      // Overflow: six back-to-back pushes into a 4-deep FIFO
      chk_gap = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 6; i++) begin
         drive_push(16'(i + 1), i < 5);
         @(negedge clk);
         check("ovf_count", 32'(fifo_count), 32'(ovf_cnt[i]));
      end
      check("ovf_flag", 32'(overflow), 32'd1);
      wait_busy_low(800, n);
      check("ovf_busy_timeout", 32'(n < 800), 32'd1);
      check("ovf_rx_done", 32'(exp_q.size()), 32'd0);
      check("ovf_sticky", 32'(overflow), 32'd1);
      chk_gap = 1'b0;

      do_reset();
      @(negedge clk);
      check("ovf_cleared_by_reset", 32'(overflow), 32'd0);

      // Full plus pop
      for (int i = 0; i < 5; i++) begin
         drive_push(fp_words[i], 1'b1);
         @(negedge clk);
         check("fp_fill_count", 32'(fifo_count), 32'(fp_cnt[i]));
      end
      repeat (WORD_CYC - 3) @(posedge clk);
      @(negedge clk);
      check("fp_full_before_pop", 32'(fifo_count), 32'd4);
      check("fp_gap_tx_high", 32'(tx), 32'd1);
      drive_push(fp_words[5], 1'b1);
      @(negedge clk);
      check("fp_count_stays_full", 32'(fifo_count), 32'd4);
      check("fp_no_overflow", 32'(overflow), 32'd0);
      check("fp_next_start", 32'(tx), 32'd0);
      wait_busy_low(800, n);
      check("fp_busy_timeout", 32'(n < 800), 32'd1);
      check("fp_rx_done", 32'(exp_q.size()), 32'd0);
      check("fp_no_overflow_end", 32'(overflow), 32'd0);

      // Reset mid-frame (data bit 3 of low byte 0xC3 is 0)
      @(negedge clk);
      drive_push(16'h3CC3, 1'b1);
      drive_push(16'h5AA5, 1'b1);
      repeat (17) @(posedge clk);
      #2;
      check("mid_bit3_low", 32'(tx), 32'd0);
      rst_n = 1'b0;
      #1;
      check("mid_reset_tx", 32'(tx), 32'd1);
      check("mid_reset_count", 32'(fifo_count), 32'd0);
      check("mid_reset_busy", 32'(busy), 32'd0);
      exp_q.delete();
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      zeros = 0;
      repeat (100) begin
         @(negedge clk);
         if (tx !== 1'b1) zeros++;
      end
      check("mid_no_residual", 32'(zeros), 32'd0);
      check("mid_busy_after", 32'(busy), 32'd0);

`ifdef OUT_PORT_TX_PARITY_EN
      // Parity: low byte 0xFF -> parity 0, high byte 0x01 -> parity 1
      drive_push(16'h01FF, 1'b1);
      @(negedge clk);
      @(negedge clk);
      cyc0 = cyc;
      repeat (37) @(negedge clk);
      check("par_low_bit", 32'(tx), 32'd0);
      repeat (44) @(negedge clk);
      check("par_high_bit", 32'(tx), 32'd1);
      wait_busy_low(200, n);
      check("par_busy_timeout", 32'(n < 200), 32'd1);
      check("par_word_len", 32'(cyc - cyc0), 32'd88);
      check("par_rx_done", 32'(exp_q.size()), 32'd0);
`endif

      repeat (20) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
